// File: rtl/snake_px_sink.sv
// rtl/snake_px_sink.sv - Avalon-MM pixel sink buffering writes into a frame RAM.
// Optional range checking is enabled by defining SNAKE_PX_SINK_BOUNDS_CHECK_EN.
module snake_px_sink #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] px_address,
  input  logic        px_read,
  input  logic        px_write,
  input  logic [15:0] px_writedata,
  output logic        px_waitrequest,
  output logic [15:0] px_readdata,
  output logic [16:0] fb_addr,
  output logic        fb_we,
  output logic [15:0] fb_wdata,
  input  logic [15:0] fb_rdata,
  output logic [15:0] drop_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RD_DRAIN, RD_ISSUE} state_t;

  logic [8:0]  px_x;
  logic [7:0]  px_y;
  logic [16:0] px_fb_addr;
  logic        px_oob;
  wire         unused_addr_bits = &{1'b0, px_address[31:18], px_address[0]};

  assign px_x = px_address[9:1];
  assign px_y = px_address[17:10];
  // y*320 as y*256 + y*64 keeps the address path free of a multiplier
  assign px_fb_addr = ({9'd0, px_y} << 8) + ({9'd0, px_y} << 6) + {8'd0, px_x};

`ifdef SNAKE_PX_SINK_BOUNDS_CHECK_EN
  assign px_oob = (px_x >= 9'd320) || (px_y >= 8'd240);
`else
  assign px_oob = 1'b0;
`endif

  logic [32:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  state_t        state_q, state_d;
  logic          issued_q, issued_d;
  logic          rd_oob_q, rd_oob_d;
  logic          fifo_empty, fifo_full, push, pop, rd_req, rd_present, rd_done;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign push       = px_write && !fifo_full && !px_oob;
  assign pop        = !fifo_empty && (state_q != RD_ISSUE);
  assign rd_req     = px_read && !px_write;

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    rd_oob_d   = rd_oob_q;
    rd_present = 1'b0;
    rd_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          rd_oob_d = px_oob;
          if (px_oob) begin
            state_d  = RD_ISSUE;
            issued_d = 1'b1;
          end else if (!fifo_empty) begin
            state_d = RD_DRAIN;
          end else begin
            rd_present = 1'b1;
            state_d    = RD_ISSUE;
            issued_d   = 1'b1;
          end
        end
      end
      RD_DRAIN: begin
        // The RAM port is free only once nothing pops; otherwise RD_ISSUE presents the address itself
        if (fifo_empty) begin
          rd_present = 1'b1;
          state_d    = RD_ISSUE;
          issued_d   = 1'b1;
        end else if (count_q == (AW+1)'(1)) begin
          state_d  = RD_ISSUE;
          issued_d = 1'b0;
        end
      end
      RD_ISSUE: begin
        rd_present = !rd_oob_q;
        if (issued_q) begin
          rd_done  = 1'b1;
          state_d  = IDLE;
          issued_d = 1'b0;
          rd_oob_d = 1'b0;
        end else begin
          issued_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    px_waitrequest = 1'b0;
    if (!reset_n)      px_waitrequest = 1'b1;
    else if (px_write) px_waitrequest = fifo_full && !px_oob;
    else if (px_read)  px_waitrequest = !rd_done;
  end

  assign px_readdata = (reset_n && rd_done && !rd_oob_q) ? fb_rdata : 16'h0000;
  assign fb_we       = reset_n && pop;
  assign fb_wdata    = fb_we ? mem_q[rd_ptr_q][15:0] : 16'h0000;
  assign fb_addr     = !reset_n   ? 17'd0 :
                       pop        ? mem_q[rd_ptr_q][32:16] :
                       rd_present ? px_fb_addr : 17'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      issued_q <= 1'b0;
      rd_oob_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {px_fb_addr, px_writedata};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (pop && !push) count_q <= count_q - (AW+1)'(1);
      state_q  <= state_d;
      issued_q <= issued_d;
      rd_oob_q <= rd_oob_d;
    end
  end

`ifdef SNAKE_PX_SINK_BOUNDS_CHECK_EN
  logic [15:0] drop_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                       drop_q <= 16'h0000;
    else if (px_write && px_oob && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
  end
  assign drop_count = drop_q;
`else
  assign drop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_snake_px_sink.sv
// tb/tb_snake_px_sink.sv - Directed self-checking bench for snake_px_sink.
module tb_snake_px_sink;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] px_address;
  logic        px_read, px_write;
  logic [15:0] px_writedata;
  wire         px_waitrequest;
  wire  [15:0] px_readdata;
  wire  [16:0] fb_addr;
  wire         fb_we;
  wire  [15:0] fb_wdata;
  logic [15:0] fb_rdata = 16'h0000;
  wire  [15:0] drop_count;

  int checks = 0;
  int errors = 0;
  int fb_writes = 0;
  logic [15:0] ram [0:76799];

  snake_px_sink #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .px_address(px_address), .px_read(px_read),
    .px_write(px_write), .px_writedata(px_writedata), .px_waitrequest(px_waitrequest),
    .px_readdata(px_readdata), .fb_addr(fb_addr), .fb_we(fb_we), .fb_wdata(fb_wdata),
    .fb_rdata(fb_rdata), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fb_we) begin
      ram[fb_addr] <= fb_wdata;
      fb_writes    <= fb_writes + 1;
    end
    fb_rdata <= ram[fb_addr];
  end

  task automatic drive(input logic rd, input logic wr, input int x, input int y, input logic [15:0] d);
    px_read      = rd;
    px_write     = wr;
    px_address   = {14'd0, y[7:0], x[8:0], 1'b0};
    px_writedata = d;
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    drive(1'b0, 1'b1, 5, 3, 16'hABCD);
    smp;
    checks++; if (px_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_wait got %0b exp 1", px_waitrequest); end
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL rst_we got %0b exp 0", fb_we); end
    checks++; if (fb_addr !== 17'd0) begin errors++; $display("FAIL rst_addr got %0d exp 0", fb_addr); end
    checks++; if (px_readdata !== 16'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", px_readdata); end
    checks++; if (drop_count !== 16'h0) begin errors++; $display("FAIL rst_drop got %0d exp 0", drop_count); end
    cyc;
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 0, 0, 16'h0);
    smp;
    checks++; if (px_waitrequest !== 1'b0) begin errors++; $display("FAIL rel_wait got %0b exp 0", px_waitrequest); end
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL rel_we got %0b exp 0", fb_we); end
  endtask

  task automatic test_write_single;
    cyc; drive(1'b0, 1'b1, 5, 3, 16'hF800); smp;
    checks++; if (px_waitrequest !== 1'b0) begin errors++; $display("FAIL wr1_wait got %0b exp 0", px_waitrequest); end
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL wr1_we0 got %0b exp 0", fb_we); end
    cyc; drive(1'b0, 1'b0, 0, 0, 16'h0); smp;
    checks++; if (fb_we !== 1'b1) begin errors++; $display("FAIL wr1_we got %0b exp 1", fb_we); end
    checks++; if (fb_addr !== 17'd965) begin errors++; $display("FAIL wr1_addr got %0d exp 965", fb_addr); end
    checks++; if (fb_wdata !== 16'hF800) begin errors++; $display("FAIL wr1_data got %h exp f800", fb_wdata); end
    cyc; smp;
    checks++; if ({fb_we, fb_addr, fb_wdata} !== 34'd0) begin errors++; $display("FAIL idle_outs got we=%0b addr=%0d data=%h exp 0", fb_we, fb_addr, fb_wdata); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) begin
      cyc;
      if (i < 5) drive(1'b0, 1'b1, i, 1, 16'h1000 + 16'(i));
      else       drive(1'b0, 1'b0, 0, 0, 16'h0);
      smp;
      if (i < 5) begin
        checks++; if (px_waitrequest !== 1'b0) begin errors++; $display("FAIL b2b_wait[%0d] got %0b exp 0", i, px_waitrequest); end
      end
      if (i == 0) begin
        checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL b2b_we[0] got %0b exp 0", fb_we); end
      end else begin
        checks++;
        if (fb_we !== 1'b1 || fb_addr !== 17'(320 + i - 1) || fb_wdata !== 16'h1000 + 16'(i - 1)) begin
          errors++;
          $display("FAIL b2b_drain[%0d] got we=%0b addr=%0d data=%h exp 1 %0d %h", i, fb_we, fb_addr, fb_wdata, 320 + i - 1, 16'h1000 + 16'(i - 1));
        end
      end
    end
    cyc; smp;
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b exp 0", fb_we); end
  endtask

  task automatic test_read_after_write;
    int stalls;
    cyc; drive(1'b0, 1'b1, 10, 10, 16'h07E0); smp;
    checks++; if (px_waitrequest !== 1'b0) begin errors++; $display("FAIL raw_wwait got %0b exp 0", px_waitrequest); end
    cyc; drive(1'b1, 1'b0, 10, 10, 16'h0);
    stalls = 0;
    for (int n = 0; n < 10; n++) begin
      smp;
      if (px_waitrequest === 1'b0) break;
      stalls++;
      cyc;
    end
    checks++; if (stalls !== 2) begin errors++; $display("FAIL raw_stalls got %0d exp 2", stalls); end
    checks++; if (px_readdata !== 16'h07E0) begin errors++; $display("FAIL raw_data got %h exp 07e0", px_readdata); end
    cyc; drive(1'b0, 1'b0, 0, 0, 16'h0); smp;
    checks++; if (px_readdata !== 16'h0) begin errors++; $display("FAIL raw_after got %h exp 0", px_readdata); end
  endtask

  task automatic test_read_corner;
    cyc; drive(1'b1, 1'b0, 319, 239, 16'h0); smp;
    checks++; if (px_waitrequest !== 1'b1) begin errors++; $display("FAIL rc_stall got %0b exp 1", px_waitrequest); end
    checks++; if (fb_addr !== 17'd76799 || fb_we !== 1'b0) begin errors++; $display("FAIL rc_addr got %0d we=%0b exp 76799 0", fb_addr, fb_we); end
    checks++; if (px_readdata !== 16'h0) begin errors++; $display("FAIL rc_early got %h exp 0", px_readdata); end
    cyc; smp;
    checks++; if (px_waitrequest !== 1'b0) begin errors++; $display("FAIL rc_done got %0b exp 0", px_waitrequest); end
    checks++; if (px_readdata !== 16'h71A5) begin errors++; $display("FAIL rc_data got %h exp 71a5", px_readdata); end
    cyc; drive(1'b0, 1'b0, 0, 0, 16'h0); smp;
  endtask

  task automatic test_bounds;
`ifdef SNAKE_PX_SINK_BOUNDS_CHECK_EN
    cyc; drive(1'b0, 1'b1, 320, 0, 16'h1234); smp;
    checks++; if (px_waitrequest !== 1'b0) begin errors++; $display("FAIL oob_wait got %0b exp 0", px_waitrequest); end
    cyc; drive(1'b0, 1'b0, 0, 0, 16'h0); smp;
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL oob_we got %0b exp 0", fb_we); end
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL oob_drop got %0d exp 1", drop_count); end
    cyc; drive(1'b1, 1'b0, 0, 240, 16'h0); smp;
    checks++; if (px_waitrequest !== 1'b1 || fb_addr !== 17'd0) begin errors++; $display("FAIL oobr_stall got %0b addr=%0d exp 1 0", px_waitrequest, fb_addr); end
    cyc; smp;
    checks++; if (px_waitrequest !== 1'b0 || px_readdata !== 16'h0) begin errors++; $display("FAIL oobr_done got %0b data=%h exp 0 0", px_waitrequest, px_readdata); end
    cyc; drive(1'b0, 1'b1, 400, 0, 16'h5555);
    repeat (70000) @(posedge clk);
    #1; drive(1'b0, 1'b0, 0, 0, 16'h0); smp;
    checks++; if (drop_count !== 16'hFFFF) begin errors++; $display("FAIL oob_sat got %h exp ffff", drop_count); end
`else
    cyc; drive(1'b0, 1'b1, 320, 0, 16'h1234); smp;
    checks++; if (px_waitrequest !== 1'b0) begin errors++; $display("FAIL nochk_wait got %0b exp 0", px_waitrequest); end
    cyc; drive(1'b0, 1'b0, 0, 0, 16'h0); smp;
    checks++; if (fb_we !== 1'b1 || fb_addr !== 17'd320 || fb_wdata !== 16'h1234) begin errors++; $display("FAIL nochk_wr got we=%0b addr=%0d data=%h exp 1 320 1234", fb_we, fb_addr, fb_wdata); end
    checks++; if (drop_count !== 16'h0) begin errors++; $display("FAIL nochk_drop got %0d exp 0", drop_count); end
`endif
  endtask

  task automatic test_reset_mid;
    int w0;
    cyc; drive(1'b0, 1'b1, 1, 2, 16'hAAAA); smp;
    cyc; drive(1'b0, 1'b1, 2, 2, 16'hBBBB); reset_n = 1'b0; smp;
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL rmid_we got %0b exp 0", fb_we); end
    checks++; if (px_waitrequest !== 1'b1) begin errors++; $display("FAIL rmid_wait got %0b exp 1", px_waitrequest); end
    w0 = fb_writes;
    cyc; reset_n = 1'b1; drive(1'b0, 1'b0, 0, 0, 16'h0);
    repeat (4) cyc;
    smp;
    checks++; if (fb_writes !== w0) begin errors++; $display("FAIL rmid_writes got %0d exp %0d", fb_writes, w0); end
    cyc; drive(1'b1, 1'b0, 3, 3, 16'h0); smp;
    checks++; if (px_waitrequest !== 1'b1) begin errors++; $display("FAIL rrd_stall got %0b exp 1", px_waitrequest); end
    cyc; reset_n = 1'b0; smp;
    checks++; if (px_waitrequest !== 1'b1 || px_readdata !== 16'h0) begin errors++; $display("FAIL rrd_abandon got %0b data=%h exp 1 0", px_waitrequest, px_readdata); end
    cyc; reset_n = 1'b1; drive(1'b0, 1'b0, 0, 0, 16'h0); smp;
    checks++; if (px_waitrequest !== 1'b0 || px_readdata !== 16'h0 || fb_addr !== 17'd0) begin errors++; $display("FAIL rrd_idle got %0b data=%h addr=%0d exp 0 0 0", px_waitrequest, px_readdata, fb_addr); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 76800; i++) ram[i] = 16'(i) ^ 16'h5A5A;
    test_reset;
    test_write_single;
    test_back_to_back;
    test_read_after_write;
    test_read_corner;
    test_bounds;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/snake_px_sink.md
SNAKE_PX_SINK -- requirements
Module: snake_px_sink

Interface
REQ-001 The module SHALL have one clock and an asynchronous active-low reset, with ports named clk and reset_n.
REQ-002 Parameter FIFO_DEPTH SHALL default to 4; it is the number of buffered pixel writes and SHALL be a power of two, 2..16.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 px_address  in  32  Avalon-MM slave byte address: x=[9:1], y=[17:10]; bits [31:18] and [0] ignored.
REQ-006 px_read  in  1  read request, held until waitrequest is low.
REQ-007 px_write  in  1  write request, held until waitrequest is low.
REQ-008 px_writedata  in  16  RGB565 pixel.
REQ-009 px_waitrequest  out  1  stall; a transfer completes in the cycle request=1 and waitrequest=0.
REQ-010 px_readdata  out  16  read pixel, valid only in the read-completion cycle.
REQ-011 fb_addr  out  17  frame RAM word address, y*320+x.
REQ-012 fb_we  out  1  frame RAM write strobe.
REQ-013 fb_wdata  out  16  frame RAM write data.
REQ-014 fb_rdata  in  16  frame RAM read data, one cycle after fb_addr with fb_we=0.
REQ-015 drop_count  out  16  count of discarded out-of-range writes.

Function
REQ-016 fb_addr SHALL be computed as (y<<8)+(y<<6)+x in 17 bits, with no multiplier.
REQ-017 A write SHALL be accepted when px_write=1 and the FIFO is not full; it pushes {fb_addr, px_writedata} and px_waitrequest=0 that cycle.
REQ-018 px_waitrequest SHALL be 1 when px_write=1 and the FIFO is full; the write is accepted no earlier than the cycle after a pop.
REQ-019 The FIFO SHALL drain one entry per cycle (fb_we=1, fb_addr/fb_wdata from head) whenever it is non-empty and the FSM is not in RD_ISSUE.
REQ-020 Simultaneous push and pop on a full FIFO SHALL NOT be allowed; a full FIFO stalls for one cycle.
REQ-021 Simultaneous push and pop on a non-full FIFO SHALL leave occupancy unchanged.
REQ-022 The FSM SHALL have the states IDLE, RD_DRAIN and RD_ISSUE.
REQ-023 IDLE, px_read=1, FIFO non-empty: the FSM SHALL go to RD_DRAIN with px_waitrequest=1.
REQ-024 RD_DRAIN: the FSM SHALL keep px_waitrequest=1 and keep draining, then go to RD_ISSUE in the cycle after the last pop.
REQ-025 IDLE, px_read=1, FIFO empty: the FSM SHALL drive fb_addr with the read address and fb_we=0, go to RD_ISSUE, with px_waitrequest=1.
REQ-026 In RD_DRAIN, the read address SHALL be driven on fb_addr in the final cycle only if no pop occurs that cycle; otherwise RD_ISSUE re-presents the address and waits one more cycle.
REQ-027 RD_ISSUE, once fb_rdata reflects the read address: px_readdata=fb_rdata, px_waitrequest=0, next state IDLE.
REQ-028 Minimum read latency SHALL be 1 stall cycle, and a read SHALL always observe every previously accepted write (read-after-write coherent).
REQ-029 If px_read and px_write are both 1, the write SHALL be handled first and the read is evaluated from the next cycle.
REQ-030 px_readdata SHALL be 0 outside the read-completion cycle.
REQ-031 When idle, fb_we SHALL be 0, and fb_addr/fb_wdata SHALL be 0.

Reset
REQ-032 While reset_n=0, all flops SHALL clear immediately: FIFO empty, pointers 0, state IDLE, drop_count 0.
REQ-033 While reset_n=0, outputs SHALL be fb_we=0, fb_addr=0, fb_wdata=0, px_readdata=0 and px_waitrequest=1.
REQ-034 Reset asserted mid-drain or mid-read SHALL discard buffered writes and abandon the read without completing it.
REQ-035 After reset release, px_waitrequest SHALL be 0 in the first clk edge's cycle unless a stall condition holds.

Configuration
REQ-036 With macro SNAKE_PX_SINK_BOUNDS_CHECK_EN defined, a write with x>=320 or y>=240 SHALL be accepted without stall, not pushed, and drop_count SHALL increment, saturating at 16'hFFFF.
REQ-037 With SNAKE_PX_SINK_BOUNDS_CHECK_EN defined, an out-of-range read SHALL complete with 1 stall cycle and readdata 16'h0000, and the RAM SHALL NOT be addressed.
REQ-038 Without SNAKE_PX_SINK_BOUNDS_CHECK_EN, no range check SHALL be made, fb_addr SHALL be used unmodified, and drop_count SHALL be tied to 0.

Verification
REQ-039 Write (x=5,y=3,data=16'hF800) with FIFO empty -> no stall; next cycle fb_we=1, fb_addr=965, fb_wdata=16'hF800.
REQ-040 5 back-to-back writes, FIFO_DEPTH=4, px_write held -> no write stalls, since each entry drains the cycle after push; with drain blocked by a read, the 5th write stalls until a pop.
REQ-041 Write (10,10,16'h07E0) then immediate read (10,10) -> read stalls until the write drains; readdata=16'h07E0.
REQ-042 Read at (319,239) with FIFO empty -> exactly 1 stall cycle, fb_addr=76799.
REQ-043 BOUNDS_CHECK_EN: write (320,0) -> no stall, fb_we stays 0, drop_count=1; 70000 such writes -> drop_count=16'hFFFF.
REQ-044 reset_n pulsed low with 3 entries buffered -> fb_we=0 immediately, no further RAM writes after release.
